// File: rtl/alu_issuer_pkg.sv
// rtl/alu_issuer_pkg.sv - shared op codes, one-hot ALU controls, FSM states and error bits for the ALU issuer
package alu_issuer_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_ROR = 4'd4;
  localparam logic [3:0] OP_ROL = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  localparam logic [11:0] CTRL_ADD = 12'h001;
  localparam logic [11:0] CTRL_SUB = 12'h002;
  localparam logic [11:0] CTRL_SHR = 12'h004;
  localparam logic [11:0] CTRL_SHL = 12'h008;
  localparam logic [11:0] CTRL_ROR = 12'h010;
  localparam logic [11:0] CTRL_ROL = 12'h020;
  localparam logic [11:0] CTRL_AND = 12'h040;
  localparam logic [11:0] CTRL_OR  = 12'h080;
  localparam logic [11:0] CTRL_MUL = 12'h100;
  localparam logic [11:0] CTRL_DIV = 12'h200;
  localparam logic [11:0] CTRL_NEG = 12'h400;
  localparam logic [11:0] CTRL_NOT = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_DIVZERO = 1;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - op code to one-hot ALU control, legality and long-settle flag
module alu_op_decode
  import alu_issuer_pkg::*;
(
  input  logic [3:0]  op_i,
  output logic [11:0] ctrl_o,
  output logic        legal_o,
  output logic        is_long_o
);

  always_comb begin
    ctrl_o    = '0;
    legal_o   = 1'b1;
    is_long_o = 1'b0;
    case (op_i)
      OP_ADD:  ctrl_o = CTRL_ADD;
      OP_SUB:  ctrl_o = CTRL_SUB;
      OP_SHR:  ctrl_o = CTRL_SHR;
      OP_SHL:  ctrl_o = CTRL_SHL;
      OP_ROR:  ctrl_o = CTRL_ROR;
      OP_ROL:  ctrl_o = CTRL_ROL;
      OP_AND:  ctrl_o = CTRL_AND;
      OP_OR:   ctrl_o = CTRL_OR;
      OP_MUL: begin
        ctrl_o    = CTRL_MUL;
        is_long_o = 1'b1;
      end
      OP_DIV: begin
        ctrl_o    = CTRL_DIV;
        is_long_o = 1'b1;
      end
      OP_NEG:  ctrl_o = CTRL_NEG;
      OP_NOT:  ctrl_o = CTRL_NOT;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - request/issue/response sequencer in front of the combinational ALU
// Optional: ALU_ISSUER_DIVZERO_EN short-circuits divide-by-zero into an error response.
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES      = 1,
  parameter int unsigned SETTLE_CYCLES_LONG = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [11:0] alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_zhi,
  input  logic [31:0] alu_zlo,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic [1:0]  rsp_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES_LONG > SETTLE_CYCLES) ? SETTLE_CYCLES_LONG
                                                                         : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(SETTLE_CYCLES_LONG - 1);

  state_e            state_q, state_d;
  logic [11:0]       ctrl_q, ctrl_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [1:0]        err_q, err_d;

  logic [11:0]       dec_ctrl;
  logic              dec_legal;
  logic              dec_long;
  logic              div_zero;

  alu_op_decode u_decode (
    .op_i      (req_op),
    .ctrl_o    (dec_ctrl),
    .legal_o   (dec_legal),
    .is_long_o (dec_long)
  );

`ifdef ALU_ISSUER_DIVZERO_EN
  assign div_zero = (req_op == OP_DIV) && (req_b == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  // Control and valid are decoded from state so an async reset drops them at once.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_ctrl  = (state_q == ST_ISSUE) ? ctrl_q : 12'h000;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d    = req_a;
          b_d    = req_b;
          ctrl_d = dec_ctrl;
          cnt_d  = dec_long ? CNT_LONG : CNT_SHORT;
          if (!dec_legal) begin
            state_d            = ST_RESP;
            hi_d               = 32'd0;
            lo_d               = 32'd0;
            err_d              = 2'b00;
            err_d[ERR_ILLEGAL] = 1'b1;
          end else if (div_zero) begin
            state_d            = ST_RESP;
            hi_d               = 32'd0;
            lo_d               = 32'd0;
            err_d              = 2'b00;
            err_d[ERR_DIVZERO] = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          hi_d    = alu_zhi;
          lo_d    = alu_zlo;
          err_d   = 2'b00;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - scoreboard bench for alu_op_issuer with a behavioural ALU stub
module tb_alu_op_issuer;
  import alu_issuer_pkg::*;

  localparam int SC  = 1;
  localparam int SCL = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_zhi, alu_zlo;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_hi, rsp_lo;
  logic [1:0]  rsp_err;

  alu_op_issuer #(.SETTLE_CYCLES(SC), .SETTLE_CYCLES_LONG(SCL)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_zhi(alu_zhi), .alu_zlo(alu_zlo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  err;
    int          acc;
    int          dly;
    int          nctrl;
    logic [11:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int accepts = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // What the ALU itself computes for an op, as seen on {ZHI, ZLO}.
  function automatic logic [63:0] alu_fn(int op, logic [31:0] a, logic [31:0] b);
    logic [63:0] t;
    case (op)
      0:  return {32'd0, a + b};
      1:  return {32'd0, a - b};
      2:  return {32'd0, a >> b[4:0]};
      3:  return {32'd0, a << b[4:0]};
      4: begin t = {a, a} >> b[4:0]; return {32'd0, t[31:0]}; end
      5: begin t = {a, a} << b[4:0]; return {32'd0, t[63:32]}; end
      6:  return {32'd0, a & b};
      7:  return {32'd0, a | b};
      8:  return {32'd0, a} * {32'd0, b};
      9:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      10: return {32'd0, 32'd0 - a};
      11: return {32'd0, ~a};
      default: return 64'h0;
    endcase
  endfunction

  // ALU stub: results are only correct once control has been stable for the op's settle time.
  int          hc = 0;
  logic [11:0] last_ctrl = 12'h0;
  logic [63:0] stub_r;
  int          stub_idx;
  int          stub_need;

  always @(negedge clock) begin
    if (alu_ctrl != 12'h0 && alu_ctrl == last_ctrl) hc <= hc + 1;
    else if (alu_ctrl != 12'h0) hc <= 1;
    else hc <= 0;
    last_ctrl <= alu_ctrl;
  end

  always_comb begin
    stub_idx = 0;
    for (int k = 0; k < 12; k++) if (alu_ctrl[k]) stub_idx = k;
    stub_need = (stub_idx == 8 || stub_idx == 9) ? SCL : SC;
    stub_r = alu_fn(stub_idx, alu_a, alu_b);
    if (!$onehot(alu_ctrl)) stub_r = 64'hDEAD_BEEF_DEAD_BEEF;
    else if (hc < stub_need) stub_r = stub_r ^ 64'hBAD0_BAD0_BAD0_BAD0;
    {alu_zhi, alu_zlo} = stub_r;
  end

  // Reference model: the response and timing the issuer owes for a request accepted at edge acc.
  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b, int acc);
    exp_t e;
    int n;
    e.acc = acc; e.hi = 32'd0; e.lo = 32'd0; e.err = 2'b00;
    e.dly = 0; e.nctrl = 0; e.ctrl = 12'h0;
    if (op > 4'd11) e.err = 2'b01;
`ifdef ALU_ISSUER_DIVZERO_EN
    else if (op == 4'd9 && b == 32'd0) e.err = 2'b10;
`endif
    else begin
      n = (op == 4'd8 || op == 4'd9) ? SCL : SC;
      {e.hi, e.lo} = alu_fn(int'(op), a, b);
      e.dly = n;
      e.nctrl = n;
      e.ctrl = 12'h001 << op;
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic mon_step();
    bit idle;
    bit ev;
    logic [11:0] ec;
    idle = (sb.size() == 0);
    ev = 1'b0;
    ec = 12'h0;
    if (!idle) begin
      ev = (cyc >= sb[0].acc + sb[0].dly);
      if (cyc >= sb[0].acc && cyc < sb[0].acc + sb[0].nctrl) ec = sb[0].ctrl;
    end
    chk("rsp_valid", rsp_valid, ev);
    chk("req_ready", req_ready, idle);
    chk("alu_ctrl", alu_ctrl, ec);
    if (ev && rsp_valid) begin
      chk("rsp_hi", rsp_hi, sb[0].hi);
      chk("rsp_lo", rsp_lo, sb[0].lo);
      chk("rsp_err", rsp_err, sb[0].err);
      if (rsp_ready) void'(sb.pop_front());
    end
    if (idle && req_valid) begin
      sb.push_back(model(req_op, req_a, req_b, cyc + 1));
      accepts++;
    end
  endtask

  always @(negedge clock) if (reset_n) mon_step();

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clock); #2;
      t++;
    end
    chk("idle_timeout", sb.size() == 0, 1);
  endtask

  task automatic wait_accepts(int target, string nm);
    int t = 0;
    while (accepts < target && t < 100) begin
      @(posedge clock); #2;
      t++;
    end
    chk(nm, accepts >= target, 1);
  endtask

  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int a0;
    wait_idle();
    a0 = accepts;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    wait_accepts(a0 + 1, "accept_timeout");
    req_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int a0;
    int t;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rsp_hi", rsp_hi, 0);
    chk("rst_rsp_lo", rsp_lo, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    send(OP_ADD, 32'd5, 32'd7);
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    send(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
    send(OP_DIV, 32'd7, 32'd0);
    send(OP_DIV, 32'd100, 32'd7);
    send(OP_ROR, 32'h8000_0001, 32'd1);
    send(OP_NEG, 32'd1, 32'd0);

    // Backpressure with a second request held valid throughout.
    wait_idle();
    rsp_ready = 1'b0;
    a0 = accepts;
    req_valid = 1'b1; req_op = OP_SUB; req_a = 32'd9; req_b = 32'd4;
    wait_accepts(a0 + 1, "bp_accept_timeout");
    req_op = OP_ADD; req_a = 32'd1; req_b = 32'd2;
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clock); #2;
      t++;
    end
    chk("bp_rsp_timeout", rsp_valid, 1);
    repeat (5) begin
      @(posedge clock); #2;
      chk("bp_rsp_lo", rsp_lo, 32'd5);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    wait_accepts(a0 + 2, "bp_second_accept");
    req_valid = 1'b0;
    wait_idle();

    // Reset while a rol is issuing.
    a0 = accepts;
    req_valid = 1'b1; req_op = OP_ROL; req_a = 32'h8000_0001; req_b = 32'd4;
    @(posedge clock); #2;
    req_valid = 1'b0;
    chk("rst_accepted", accepts, a0 + 1);
    #1;
    chk("ctrl_before_reset", alu_ctrl, CTRL_ROL);
    reset_n = 1'b0;
    #1;
    chk("ctrl_in_reset", alu_ctrl, 0);
    chk("rsp_valid_in_reset", rsp_valid, 0);
    chk("req_ready_in_reset", req_ready, 1);
    sb.delete();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    send(OP_ADD, 32'd100, 32'd23);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #2;
      req_valid = 1'($urandom_range(0, 1));
      req_op = 4'($urandom_range(0, 15));
      req_a = $urandom;
      req_b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
